// File: rtl/collision_pkg.sv
// Shared types and constants for the collision lookup arbiter.
package collision_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StProbe,
    StDone
  } state_e;

  localparam int unsigned CORNER_TL = 0;
  localparam int unsigned CORNER_TR = 1;
  localparam int unsigned CORNER_BL = 2;
  localparam int unsigned CORNER_BR = 3;

  localparam int unsigned DEF_SCREEN_W    = 640;
  localparam int unsigned DEF_SCREEN_H    = 480;
  localparam int unsigned DEF_SPRITE_SIZE = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from last_i+1.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int unsigned cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(last_i) + off) % NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = IDX_W'(cand);
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collision_arbiter.sv
// Shares one level_rom collision port among movers, probing four sprite corners per request.
// Optional COLL_EARLY_EXIT_EN: stop probing at the first wall corner.
module collision_arbiter
  import collision_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned SPRITE_SIZE = DEF_SPRITE_SIZE,
  parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H    = DEF_SCREEN_H
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*10-1:0] req_x,
  input  logic [NUM_REQ*10-1:0] req_y,
  input  logic [2:0]            room,
  output logic [9:0]            rom_x,
  output logic [9:0]            rom_y,
  output logic [2:0]            rom_room,
  input  logic                  rom_wall,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  hit,
  output logic [3:0]            hit_mask,
  output logic                  busy
);

  localparam int unsigned IdxW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [9:0]  SpriteOff = 10'(SPRITE_SIZE);

  state_e               state_q, state_d;
  logic [1:0]           corner_q, corner_d;
  logic [9:0]           lx_q, lx_d, ly_q, ly_d;
  logic [2:0]           room_q, room_d;
  logic [IdxW-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [3:0]           acc_q, acc_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 hit_q, hit_d;
  logic [3:0]           hit_mask_q, hit_mask_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IdxW-1:0]      arb_idx;
  logic                 arb_valid;
  logic                 corner_wall;
  logic                 to_done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Corner address is a pure function of the latched position, so it holds in IDLE.
  assign rom_x    = lx_q + (corner_q[0] ? SpriteOff : 10'd0);
  assign rom_y    = ly_q + (corner_q[1] ? SpriteOff : 10'd0);
  assign rom_room = room_q;

  // Off-screen corners never block, so the mover can walk through a door.
  assign corner_wall = rom_wall && (32'(rom_x) < SCREEN_W) && (32'(rom_y) < SCREEN_H);

  assign ack      = ack_q;
  assign hit      = hit_q;
  assign hit_mask = hit_mask_q;
  assign busy     = busy_q;

  always_comb begin
    state_d    = state_q;
    corner_d   = corner_q;
    lx_d       = lx_q;
    ly_d       = ly_q;
    room_d     = room_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    acc_d      = acc_q;
    ack_d      = '0;
    hit_d      = hit_q;
    hit_mask_d = hit_mask_q;
    to_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d  = StProbe;
          lx_d     = req_x[32'(arb_idx)*10 +: 10];
          ly_d     = req_y[32'(arb_idx)*10 +: 10];
          room_d   = room;
          last_d   = arb_idx;
          gnt_d    = arb_grant;
          corner_d = 2'(CORNER_TL);
          acc_d    = 4'b0000;
        end
      end
      StProbe: begin
        acc_d[corner_q] = corner_wall;
`ifdef COLL_EARLY_EXIT_EN
        if (corner_wall) begin
          acc_d   = 4'b0001 << corner_q;
          to_done = 1'b1;
        end
`endif
        if (!to_done) begin
          if (corner_q == 2'(CORNER_BR)) to_done = 1'b1;
          else corner_d = corner_q + 2'd1;
        end
        if (to_done) begin
          state_d    = StDone;
          ack_d      = gnt_q;
          hit_d      = |acc_d;
          hit_mask_d = acc_d;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      corner_q   <= 2'd0;
      lx_q       <= 10'd0;
      ly_q       <= 10'd0;
      room_q     <= 3'd0;
      last_q     <= IdxW'(NUM_REQ - 1);
      gnt_q      <= '0;
      acc_q      <= 4'b0000;
      ack_q      <= '0;
      hit_q      <= 1'b0;
      hit_mask_q <= 4'b0000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      corner_q   <= corner_d;
      lx_q       <= lx_d;
      ly_q       <= ly_d;
      room_q     <= room_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      acc_q      <= acc_d;
      ack_q      <= ack_d;
      hit_q      <= hit_d;
      hit_mask_q <= hit_mask_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_collision_arbiter.sv
// Self-checking bench for collision_arbiter: vector table, random requests, reset/RR/drop cases.
module tb_collision_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  req;
  logic [39:0] req_x;
  logic [39:0] req_y;
  logic [2:0]  room;
  logic [9:0]  rom_x;
  logic [9:0]  rom_y;
  logic [2:0]  rom_room;
  logic        rom_wall;
  logic [3:0]  ack;
  logic        hit;
  logic [3:0]  hit_mask;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int model_last = 3;

  int wall_mode = 0;
  int wall_px   = 0;
  int wall_py   = 0;
  int wall_seed = 0;

  collision_arbiter dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .req      (req),
    .req_x    (req_x),
    .req_y    (req_y),
    .room     (room),
    .rom_x    (rom_x),
    .rom_y    (rom_y),
    .rom_room (rom_room),
    .rom_wall (rom_wall),
    .ack      (ack),
    .hit      (hit),
    .hit_mask (hit_mask),
    .busy     (busy)
  );

  always #5 Clk = ~Clk;

  // Level map: 0 open, 1 single wall pixel, 2 solid, 3 pseudo-random pattern.
  function automatic logic wall_fn(input int x, input int y, input int r);
    case (wall_mode)
      0:       return 1'b0;
      1:       return (x == wall_px) && (y == wall_py);
      2:       return 1'b1;
      default: return ((x * 7 + y * 13 + r * 5 + wall_seed) % 5) == 0;
    endcase
  endfunction

  always @(rom_x or rom_y or rom_room or wall_mode or wall_px or wall_py or wall_seed)
    rom_wall = wall_fn(int'(rom_x), int'(rom_y), int'(rom_room));

  function automatic void ref_result(input int x, input int y, input int r,
                                     output int mask, output int lat);
    int px, py;
    bit w, stop;
    mask = 0;
    lat  = 5;
    stop = 0;
    for (int c = 0; c < 4; c++) begin
      px = (x + ((c % 2) != 0 ? 32 : 0)) % 1024;
      py = (y + ((c / 2) != 0 ? 32 : 0)) % 1024;
      w  = (px < 640) && (py < 480) && wall_fn(px, py, r);
      if (!stop && w) begin
`ifdef COLL_EARLY_EXIT_EN
        mask = 1 << c;
        lat  = c + 2;
        stop = 1;
`else
        mask = mask | (1 << c);
`endif
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One solo request; checks probe addresses, latency and result.
  task automatic serve(input int idx, input int x, input int y, input int rm,
                       input int exp_mask, input int exp_lat, input string nm);
    bit got;
    int c;
    @(negedge Clk);
    req = 4'b0000;
    req[idx] = 1'b1;
    req_x[idx*10 +: 10] = 10'(x);
    req_y[idx*10 +: 10] = 10'(y);
    room = 3'(rm);
    got = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge Clk);
      if (ack != 4'b0000) begin
        got = 1;
        chk({nm, " ack"}, int'(ack), 1 << idx);
        chk({nm, " latency"}, n, exp_lat);
        chk({nm, " hit"}, int'(hit), int'(exp_mask != 0));
        chk({nm, " hit_mask"}, int'(hit_mask), exp_mask);
        req = 4'b0000;
      end else if (n <= 4) begin
        c = n - 1;
        chk({nm, " rom_x"}, int'(rom_x), (x + ((c % 2) != 0 ? 32 : 0)) % 1024);
        chk({nm, " rom_y"}, int'(rom_y), (y + ((c / 2) != 0 ? 32 : 0)) % 1024);
        chk({nm, " rom_room"}, int'(rom_room), rm);
        chk({nm, " busy"}, int'(busy), 1);
      end
    end
    if (!got) chk({nm, " ack timeout"}, 0, 1);
    model_last = idx;
    @(negedge Clk);
    chk({nm, " ack cleared"}, int'(ack), 0);
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    int idx;
    int x;
    int y;
    int mode;
    int wpx;
    int wpy;
    int exp_mask;
    int exp_lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    int m, l, got_n, last_n, seen, ack2;
    bit got;
`ifdef COLL_EARLY_EXIT_EN
    vt[0] = '{0, 100, 100, 0, 0,   0,   4'b0000, 5};
    vt[1] = '{1, 100, 100, 1, 132, 132, 4'b1000, 5};
    vt[2] = '{2, 100, 100, 1, 132, 100, 4'b0010, 3};
    vt[3] = '{3, 620, 100, 2, 0,   0,   4'b0001, 2};
    vt[4] = '{0, 1000, 100, 2, 0,  0,   4'b0010, 3};
    vt[5] = '{1, 100, 460, 2, 0,   0,   4'b0001, 2};
    vt[6] = '{2, 608, 448, 2, 0,   0,   4'b0001, 2};
`else
    vt[0] = '{0, 100, 100, 0, 0,   0,   4'b0000, 5};
    vt[1] = '{1, 100, 100, 1, 132, 132, 4'b1000, 5};
    vt[2] = '{2, 100, 100, 1, 132, 100, 4'b0010, 5};
    vt[3] = '{3, 620, 100, 2, 0,   0,   4'b0101, 5};
    vt[4] = '{0, 1000, 100, 2, 0,  0,   4'b1010, 5};
    vt[5] = '{1, 100, 460, 2, 0,   0,   4'b0011, 5};
    vt[6] = '{2, 608, 448, 2, 0,   0,   4'b0001, 5};
`endif

    Reset_n = 1'b0;
    req     = 4'b0000;
    req_x   = '0;
    req_y   = '0;
    room    = 3'd0;
    #1;
    chk("reset ack", int'(ack), 0);
    chk("reset hit", int'(hit), 0);
    chk("reset hit_mask", int'(hit_mask), 0);
    chk("reset busy", int'(busy), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      wall_mode = vt[i].mode;
      wall_px   = vt[i].wpx;
      wall_py   = vt[i].wpy;
      serve(vt[i].idx, vt[i].x, vt[i].y, i % 8, vt[i].exp_mask, vt[i].exp_lat,
            $sformatf("vec%0d", i));
    end

    wall_mode = 3;
    for (int i = 0; i < 40; i++) begin
      int idx, x, y, rm;
      wall_seed = $urandom_range(0, 4);
      idx = $urandom_range(0, 3);
      x   = $urandom_range(0, 1023);
      y   = $urandom_range(0, 1023);
      rm  = $urandom_range(0, 7);
      ref_result(x, y, rm, m, l);
      serve(idx, x, y, rm, m, l, $sformatf("rnd%0d", i));
    end

    // Leave a nonzero result visible, then reset in the middle of a probe.
    wall_mode = 2;
    ref_result(100, 100, 0, m, l);
    serve(0, 100, 100, 0, m, l, "pre-reset");
    wall_mode = 0;
    @(negedge Clk);
    req = 4'b0001;
    req_x[9:0] = 10'd200;
    req_y[9:0] = 10'd200;
    repeat (3) @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    chk("midreset ack", int'(ack), 0);
    chk("midreset hit", int'(hit), 0);
    chk("midreset hit_mask", int'(hit_mask), 0);
    chk("midreset busy", int'(busy), 0);
    chk("midreset rom_x", int'(rom_x), 0);
    @(negedge Clk);
    req = 4'b0110;
    req_x[19:10] = 10'd50;
    req_y[19:10] = 10'd60;
    req_x[29:20] = 10'd70;
    req_y[29:20] = 10'd80;
    Reset_n = 1'b1;
    got = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge Clk);
      if (ack != 4'b0000) begin
        got = 1;
        chk("post-reset first ack", int'(ack), 4'b0010);
        chk("post-reset latency", n, 5);
        req = 4'b0100;
      end
    end
    if (!got) chk("post-reset ack timeout", 0, 1);
    got = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge Clk);
      if (ack != 4'b0000) begin
        got = 1;
        chk("post-reset second ack", int'(ack), 4'b0100);
        chk("post-reset second gap", n, 6);
        req = 4'b0000;
      end
    end
    if (!got) chk("post-reset second timeout", 0, 1);
    repeat (2) @(negedge Clk);
    model_last = 2;

    // Requester 2 drops after grant; still gets its ack, then 3 is served.
    req = 4'b0100;
    req_x[39:30] = 10'd300;
    req_y[39:30] = 10'd300;
    seen = 0;
    ack2 = 0;
    last_n = 0;
    for (int n = 1; n <= 30 && seen < 2; n++) begin
      @(negedge Clk);
      if (n == 1) req = 4'b1001;
      if (ack[2]) ack2++;
      if (ack != 4'b0000) begin
        if (seen == 0) begin
          chk("drop first ack", int'(ack), 4'b0100);
          chk("drop first latency", n, 5);
        end else begin
          chk("drop next ack", int'(ack), 4'b1000);
          chk("drop next gap", n - last_n, 6);
          req = 4'b0000;
        end
        seen++;
        last_n = n;
      end
    end
    if (seen < 2) chk("drop ack timeout", seen, 2);
    repeat (3) @(negedge Clk);
    if (ack[2]) ack2++;
    chk("drop ack2 pulses", ack2, 1);
    model_last = 3;

    // All four requesting: fair rotation, 6 cycles apart.
    req = 4'b1111;
    seen = 0;
    last_n = 0;
    for (int n = 1; n <= 60 && seen < 5; n++) begin
      @(negedge Clk);
      if (ack != 4'b0000) begin
        got_n = oh_idx(ack);
        chk($sformatf("rr ack%0d idx", seen), got_n, (model_last + 1) % 4);
        chk($sformatf("rr ack%0d onehot", seen), int'(ack), 1 << ((model_last + 1) % 4));
        chk($sformatf("rr ack%0d gap", seen), n - last_n, (seen == 0) ? 5 : 6);
        model_last = (model_last + 1) % 4;
        last_n = n;
        seen++;
        if (seen == 5) req = 4'b0000;
      end
    end
    if (seen < 5) chk("rr ack timeout", seen, 5);
    repeat (3) @(negedge Clk);
    chk("final idle busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collision_arbiter.md
Name: collision_arbiter

Overview:
- Shares the single level_rom collision lookup port between up to NUM_REQ movers: player plus enemies.
- Each requester submits a proposed top-left position. The block grants requesters round-robin and probes the four sprite corners through the ROM, one per cycle.
- It returns a per-requester ack pulse with a wall-hit flag and a corner mask.
- Sits between the movers' position-update logic and level_rom, replacing per-mover combinational ROM instances.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 is the player.
- SPRITE_SIZE, 32, corner offset added to x/y for right/bottom corners.
- SCREEN_W, 640, x at or above this is off-screen.
- SCREEN_H, 480, y at or above this is off-screen.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_x  in  NUM_REQ*10  packed proposed X; slice i belongs to requester i.
- req_y  in  NUM_REQ*10  packed proposed Y.
- room  in  3  current room number.
- rom_x  out  10  level_rom DrawX.
- rom_y  out  10  level_rom DrawY.
- rom_room  out  3  level_rom room.
- rom_wall  in  1  level_rom bg_type; combinational response to rom_x/rom_y/rom_room.
- ack  out  NUM_REQ  one-hot, one-cycle result-valid pulse.
- hit  out  1  any probed corner is a wall; valid while ack != 0.
- hit_mask  out  4  per-corner wall flags: bit0 TL, bit1 TR, bit2 BL, bit3 BR; valid with ack.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, Reset_n low):
  - state = IDLE; ack = 0, hit = 0, hit_mask = 0, busy = 0.
  - Corner counter = 0; latched coordinates = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first after reset.
- States: IDLE, PROBE, DONE.
- IDLE:
  - If req != 0, grant the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - At that edge: latch req_x/req_y slice and room, set last_grant, corner = 0, clear hit_mask, go to PROBE.
- PROBE:
  - rom_x = lx + (corner[0] ? SPRITE_SIZE : 0) and rom_y = ly + (corner[1] ? SPRITE_SIZE : 0); 10-bit add, wrap mod 1024. rom_room = latched room.
  - At each edge, set hit_mask[corner] = rom_wall, except a corner with rom_x >= SCREEN_W or rom_y >= SCREEN_H is forced open (0), so door transitions stay with the mover.
  - Corner increments 0→1→2→3. The edge that samples corner 3 goes to DONE.
- DONE, one cycle:
  - ack[granted] = 1; hit = |hit_mask; hit_mask held.
  - Next edge: ack clears, go to IDLE.
  - hit/hit_mask hold their value until the next DONE.
- Latency: request seen at edge 0 → ack high in cycle 5 (1 grant + 4 probes), no early exit. Back-to-back service: a new grant at the edge leaving IDLE, i.e. 6 cycles per request.
- In IDLE, rom_x/rom_y/rom_room hold the last driven values (don't-care for the ROM).
- Requester rules:
  - Hold req high until its ack; coordinates are latched at grant, so later changes are ignored.
  - A requester dropping req mid-service still receives its ack pulse; the mover ignores it.
  - A req held high after ack is re-serviced only after other pending requesters (round-robin fairness). With all NUM_REQ requesting, each is served once per NUM_REQ×6 cycles.
- Reset asserted mid-operation aborts immediately to reset values; no ack is emitted.

Optional Feature:
- Macro: COLL_EARLY_EXIT_EN.
- Defined: in PROBE, the first corner sampled as wall jumps straight to DONE.
  - hit = 1; hit_mask has only that corner bit set; later corners are not probed.
  - Minimum latency: ack in cycle 2.
- Undefined: all four corners are always probed, giving fixed 5-cycle latency and a complete hit_mask.

Decomposition:
- collision_pkg:
  - state enum {IDLE, PROBE, DONE}.
  - corner index constants CORNER_TL = 0, CORNER_TR = 1, CORNER_BL = 2, CORNER_BR = 3.
  - Default SCREEN_W/SCREEN_H/SPRITE_SIZE constants.
- Sub-module rr_arbiter: combinational round-robin pick from req and last_grant, producing a one-hot grant and its index. It is instanced once.

Test Plan:
- Reset released, req = 4'b0001, req_x[0] = 100, req_y[0] = 100, all ROM open → rom_x/rom_y sequence (100,100), (132,100), (100,132), (132,132); ack = 4'b0001 in cycle 5; hit = 0; hit_mask = 0.
- Same request, ROM wall only at (132,132) → hit = 1, hit_mask = 4'b1000. With COLL_EARLY_EXIT_EN and a wall at (132,100): ack in cycle 3, hit_mask = 4'b0010, and (100,132) is never driven.
- req = 4'b1111 held → ack order 0,1,2,3,0, with consecutive acks 6 cycles apart.
- req_x = 620 → corners at x = 652 are forced open even when ROM returns wall; x = 1000 gives rom_x = 8 (wrap), which is probed normally.
- Reset_n pulsed low in PROBE corner 2 → outputs zero asynchronously. After release with req = 4'b0110, requester 1 is served first (last_grant reset to 3).
- req[2] dropped after grant → ack[2] still pulses once; the next grant goes to the next pending requester.
